mem_bus_responder: RTL
======================

Name: mem_bus_responder

Overview:
Target end of the byte-wide memory bus driven by the CPU memory controller: it owns the mem_a / mem_wr / mem_dout inputs and returns mem_din and io_buffer_full. It contains a byte RAM and a memory-mapped I/O region selected by mem_a[17:16]==2'b11. The I/O region contains a UART-style TX FIFO, an RX FIFO, a status register and a simulation-exit port. It sits between the CPU top and the host/UART side, in place of the external RAM and I/O hub.

Parameters:
ADDR_WIDTH, 17, RAM holds 2^ADDR_WIDTH bytes, indexed by mem_a[ADDR_WIDTH-1:0]
FIFO_DEPTH, 8, entries in each of the TX and RX byte FIFOs (power of 2, >=4)
INIT_FILE, "", hex file loaded into RAM at elaboration when non-empty; RAM is not reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_a  in  32  byte address from the controller; 0 when the bus is idle
mem_wr  in  1  1 = write mem_dout to mem_a this cycle; 0 = read
mem_dout  in  8  write data from the controller
mem_din  out  8  read data; valid one cycle after the address
io_buffer_full  out  1  TX FIFO near-full; the controller must not start an I/O access while this is high
tx_data  out  8  head of the TX FIFO
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  host pops the TX head on tx_valid&&tx_ready
rx_data  in  8  incoming host byte
rx_valid  in  1  host offers rx_data
rx_ready  out  1  RX FIFO not full; a byte is pushed on rx_valid&&rx_ready
sim_exit  out  1  one-cycle pulse on a write to EXIT_ADDR
sim_code  out  8  exit code; holds the last value written to EXIT_ADDR

Behaviour:
- Decode: io = (mem_a[17:16]==2'b11); otherwise the access is a RAM access at mem_a[ADDR_WIDTH-1:0]. Upper address bits are ignored.
- RAM write: on a clock edge with mem_wr=1 and !io, ram[addr] <= mem_dout. This is single-cycle; no handshake.
- RAM read: on a clock edge with mem_wr=0 and !io, mem_din <= ram[addr]. This gives exactly one cycle of latency.
- Back-to-back reads at addresses a, a+1, a+2, a+3 on consecutive cycles return their bytes on the next four consecutive cycles.
- The idle bus (mem_a=0, mem_wr=0) reads ram[0]; this read has no side effects.
- I/O map (low byte of mem_a; bits 15:8 ignored):
  - 0x30000 DATA. Write pushes mem_dout into the TX FIFO. Read pops the RX FIFO, and mem_din <= head byte on the next cycle. A read with the RX FIFO empty returns 0x00 and does not pop.
  - 0x30004 STATUS/EXIT. Read returns {5'b0, tx_overflow, tx_full, rx_nonempty}. Write sets sim_code <= mem_dout and pulses sim_exit for one cycle.
  - Any other I/O offset: reads return 0x00; writes are ignored.
- One-pop rule: an I/O read pops at most one RX byte per cycle. The controller holds the same address for two cycles only when idle=0, so the pop is qualified on a change of address or on the previous cycle not having been a DATA read. Consequently, a DATA read held on the bus for N consecutive cycles pops exactly one byte.
- TX FIFO:
  - A push and a host pop in the same cycle leave the count unchanged and both take effect.
  - A push when count==FIFO_DEPTH drops the byte and sets sticky tx_overflow. tx_overflow is cleared only by reset.
- io_buffer_full is registered and is high when TX count >= FIFO_DEPTH-2. The two-entry slack covers the flag's one-cycle lag plus one in-flight write.
- RX FIFO:
  - A push and a DATA-read pop in the same cycle both take effect.
  - rx_ready is registered and equals !(count==FIFO_DEPTH); its reset value is 0.
  - A host byte offered while rx_ready=0 is not taken.
- Reset (asynchronous, rst_n=0, including mid-access):
  - Registered outputs: mem_din=0, io_buffer_full=0, tx_valid=0, tx_data=0, rx_ready=0, sim_exit=0, sim_code=0.
  - Internal state: both FIFOs are emptied and tx_overflow=0.
  - RAM contents are preserved.
  - The first access after reset release behaves normally.

Decomposition:
- Shared package mem_bus_pkg holds:
  - IO_SEL=2'b11 (for mem_a[17:16])
  - DATA_OFS=8'h00 and STATUS_OFS=8'h04
  - STATUS bit indices RX_NE=0, TX_FULL=1, TX_OVF=2
- One sub-module, byte_fifo (parameter DEPTH; push/pop/din/dout/count/full/empty; asynchronous active-low reset), instantiated twice: once for TX, once for RX.
- The RAM array and address decode stay in the top level.

Test Plan:
- RAM write then read:
  - Stimulus: writes 0x11, 0x22, 0x33, 0x44 to 0x00100..0x00103 on four consecutive cycles; then reads the same addresses on four consecutive cycles.
  - Response: mem_din = 0x11, 0x22, 0x33, 0x44 on the four cycles following the reads.
- TX path with host stalled:
  - Stimulus: tx_ready=0; seven DATA writes of 0x41..0x47; then one more write.
  - Response: io_buffer_full=1 one cycle after the 6th write. The 8th byte is stored, making count 8; a 9th write sets STATUS bit2. Raising tx_ready drains 0x41 first.
- RX path:
  - Stimulus: host pushes 0x5A then 0xA5; a DATA read held on the bus for 2 cycles; then a second DATA read.
  - Response: 0x5A is returned and only one byte is popped by the held read; the second read returns 0xA5. A third read returns 0x00 and STATUS reads 0x00.
- Simultaneous push/pop:
  - Stimulus: TX count=3; a DATA write in the same cycle as tx_valid&&tx_ready.
  - Response: count stays 3 and FIFO order is preserved.
- Exit port:
  - Stimulus: write 0x00 to 0x30004.
  - Response: sim_exit is high for exactly 1 cycle and sim_code=0x00. A second write of 0x07 gives sim_code=0x07.
- Reset mid-operation:
  - Stimulus: TX holds 4 bytes and RX holds 2 bytes; assert rst_n=0 asynchronously between clock edges.
  - Response: all outputs reach their reset values immediately. After release, STATUS reads 0x00, and ram[0x00100] still reads 0x11.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Purpose: shared constants and access decoding for the memory-bus responder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mem_bus_pkg;

  // mem_a[17:16] value that selects the I/O region instead of RAM
  localparam logic [1:0] IO_SEL     = 2'b11;

  // I/O register offsets (low byte of mem_a)
  localparam logic [7:0] DATA_OFS   = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h04;

  // STATUS register bit positions
  localparam int RX_NE   = 0;
  localparam int TX_FULL = 1;
  localparam int TX_OVF  = 2;

  typedef enum logic [1:0] {
    ACC_RAM,
    ACC_DATA,
    ACC_STATUS,
    ACC_OTHER
  } acc_kind_e;

  // Classifies a bus access from the region-select bits and the I/O offset.
  function automatic acc_kind_e decode(input logic [1:0] sel, input logic [7:0] ofs);
    if (sel != IO_SEL)      return ACC_RAM;
    if (ofs == DATA_OFS)    return ACC_DATA;
    if (ofs == STATUS_OFS)  return ACC_STATUS;
    return ACC_OTHER;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Purpose: DEPTH-entry byte FIFO with first-word-fall-through head and occupancy count.
// Latency: a pushed byte is visible on dout_o the cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; the caller watches full_o/empty_o.
// Ports: clk, rst_n (async active-low), push_i/din_i write side, pop_i read side,
//        dout_o head byte, count_o occupancy, full_o/empty_o status.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage is cleared on reset so the head byte reads 0 while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Purpose: target of the byte-wide CPU memory bus: byte RAM plus I/O region (TX/RX FIFOs, STATUS, EXIT).
// Latency: every read returns on mem_din one cycle after the address; writes take effect at the edge.
// Backpressure: io_buffer_full warns the controller off I/O access; host sides use valid/ready.
// Ports: mem_a/mem_wr/mem_dout/mem_din bus; io_buffer_full; tx_data/tx_valid/tx_ready host TX;
//        rx_data/rx_valid/rx_ready host RX; sim_exit/sim_code simulation exit port.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int    ADDR_WIDTH = 17,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_exit,
  output logic [7:0]  sim_code
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // RAM is deliberately not reset so its contents survive rst_n.
  logic [7:0] ram [2**ADDR_WIDTH];

  acc_kind_e             kind;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  unused_addr_bits;

  assign kind             = decode(mem_a[17:16], mem_a[7:0]);
  assign ram_addr         = mem_a[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^mem_a[31:18];

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_count;
  logic [7:0]    tx_head;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] rx_count, rx_count_nxt;
  logic [7:0]    rx_head;
  logic          data_rd, fresh_rd;
  logic [7:0]    status;

  logic [7:0]    mem_din_d, mem_din_q;
  logic          io_full_q, rx_ready_q, sim_exit_q, tx_ovf_q, prev_data_rd_q;
  logic [7:0]    sim_code_q;
  logic [17:0]   prev_a_q;

  // The controller may hold a DATA read on the bus for several cycles; only the
  // first cycle of such a hold counts as a new read and may pop the RX FIFO.
  assign data_rd  = (kind == ACC_DATA) && !mem_wr;
  assign fresh_rd = data_rd && (!prev_data_rd_q || (prev_a_q != mem_a[17:0]));
  assign rx_pop   = fresh_rd && !rx_empty;
  assign rx_push  = rx_valid && rx_ready_q;
  assign tx_push  = (kind == ACC_DATA) && mem_wr;
  assign tx_pop   = tx_ready && !tx_empty;

  // rx_ready is registered from the post-edge occupancy so it tracks "not full"
  // with no lag and never accepts a byte the FIFO would have to drop.
  assign rx_count_nxt = rx_count + CW'(rx_push && !rx_full) - CW'(rx_pop);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (mem_dout),
    .dout_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (rx_data),
    .dout_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_comb begin
    status          = 8'h00;
    status[RX_NE]   = !rx_empty;
    status[TX_FULL] = tx_full;
    status[TX_OVF]  = tx_ovf_q;
  end

  // Read data mux. Writes and the non-first cycles of a held DATA read keep
  // the previously returned byte.
  always_comb begin
    mem_din_d = mem_din_q;
    if (!mem_wr) begin
      case (kind)
        ACC_RAM:    mem_din_d = ram[ram_addr];
        ACC_DATA:   if (fresh_rd) mem_din_d = rx_empty ? 8'h00 : rx_head;
        ACC_STATUS: mem_din_d = status;
        default:    mem_din_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr && (kind == ACC_RAM)) ram[ram_addr] <= mem_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din_q      <= 8'h00;
      io_full_q      <= 1'b0;
      rx_ready_q     <= 1'b0;
      sim_exit_q     <= 1'b0;
      sim_code_q     <= 8'h00;
      tx_ovf_q       <= 1'b0;
      prev_a_q       <= '0;
      prev_data_rd_q <= 1'b0;
    end else begin
      mem_din_q      <= mem_din_d;
      // Lags occupancy by one cycle; the two-entry margin absorbs that lag
      // plus one write already in flight.
      io_full_q      <= (tx_count >= CW'(FIFO_DEPTH - 2));
      rx_ready_q     <= (rx_count_nxt != CW'(FIFO_DEPTH));
      sim_exit_q     <= (kind == ACC_STATUS) && mem_wr;
      if ((kind == ACC_STATUS) && mem_wr) sim_code_q <= mem_dout;
      if (tx_push && tx_full) tx_ovf_q <= 1'b1;
      prev_a_q       <= mem_a[17:0];
      prev_data_rd_q <= data_rd;
    end
  end

  assign mem_din        = mem_din_q;
  assign io_buffer_full = io_full_q;
  assign tx_data        = tx_head;
  assign tx_valid       = !tx_empty;
  assign rx_ready       = rx_ready_q;
  assign sim_exit       = sim_exit_q;
  assign sim_code       = sim_code_q;

endmodule
